// File: rtl/simon_key_scheduler.sv
// ---------------------------------------------------------------------------
// simon_key_scheduler
//
// Streams the SIMON32/64 round-key schedule k0..k(T-1) from a master key, one
// key per valid/ready handshake. An M-word key window is held in flops. The
// window, together with the current round index, feeds a combinational key
// expander. The expander result is shifted into the top of the window each
// time a key is accepted.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   start     begin a schedule (sampled only while idle)
//   abort     cancel a schedule in progress (wins over start and handshake)
//   key_in    master key, word j = key_in[j*N +: N], word 0 = k0
//   rk_ready  consumer accepts rk this cycle
//   rk_valid  rk holds a valid round key
//   rk        current round key k(rk_index), reads 0 when not valid
//   rk_index  index of rk, saturates at T-1
//   busy      high while streaming
//   done      one-cycle pulse after k(T-1) is accepted
//   replay    (SIMON_KEYSCHED_CACHE_EN only) re-stream the cached schedule
//
// Optional feature: define SIMON_KEYSCHED_CACHE_EN to add a T x N round-key
// cache and the replay input.
// ---------------------------------------------------------------------------
module simon_key_scheduler #(
  parameter int N = 16,
  parameter int M = 4,
  parameter int T = 32,
  localparam int CW = $clog2(T)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           abort,
`ifdef SIMON_KEYSCHED_CACHE_EN
  input  logic           replay,
`endif
  input  logic [M*N-1:0] key_in,
  input  logic           rk_ready,
  output logic           rk_valid,
  output logic [N-1:0]   rk,
  output logic [CW-1:0]  rk_index,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // z0 constant sequence for SIMON32/64; element 0 is the leftmost bit.
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

  localparam logic [CW-1:0] LAST_IDX = CW'(T - 1);

  state_t         state_q, state_d;
  logic [N-1:0]   win_q [M];
  logic [N-1:0]   win_d [M];
  logic [CW-1:0]  idx_q, idx_d;
  logic [N-1:0]   exp_key;
  logic           accept;

  // One SIMON key-expansion step for M = 4:
  // k(i+4) = ~k(i) ^ 3 ^ z0[i] ^ t ^ ror(t,1), with t = ror(k(i+3),3) ^ k(i+1).
  function automatic logic [N-1:0] expand(input logic [N-1:0] k0,
                                          input logic [N-1:0] k1,
                                          input logic [N-1:0] k3,
                                          input logic [CW-1:0] cnt);
    logic [N-1:0] tmp;
    logic [5:0]   zi;
    tmp = {k3[2:0], k3[N-1:3]} ^ k1;
    tmp = tmp ^ {tmp[0], tmp[N-1:1]};
    zi  = 6'd61 - 6'(cnt);
    return ~k0 ^ tmp ^ N'(Z0[zi]) ^ N'(3);
  endfunction

  assign exp_key = expand(win_q[0], win_q[1], win_q[M-1], idx_q);
  assign accept  = (state_q == ST_RUN) && rk_ready && !abort;

`ifdef SIMON_KEYSCHED_CACHE_EN
  logic [N-1:0] cache_mem [T];
  logic         cache_valid_q, cache_valid_d;
  logic         replay_mode_q, replay_mode_d;
  logic         cache_we;

  // Only freshly computed keys are written; a replay reads the same values
  // back, so rewriting them would be pointless.
  assign cache_we = accept && !replay_mode_q;

  always_ff @(posedge clk) begin
    if (cache_we) begin
      cache_mem[idx_q] <= win_q[0];
    end
  end
`endif

  // Next-state logic. Abort is checked first in both idle and run so that it
  // dominates start and any same-cycle handshake. The final handshake does not
  // shift the window, which discards expander results beyond k(T-1).
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    idx_d   = idx_q;
`ifdef SIMON_KEYSCHED_CACHE_EN
    cache_valid_d = cache_valid_q;
    replay_mode_d = replay_mode_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!abort) begin
          if (start) begin
            for (int j = 0; j < M; j++) begin
              win_d[j] = key_in[j*N +: N];
            end
            idx_d   = '0;
            state_d = ST_RUN;
`ifdef SIMON_KEYSCHED_CACHE_EN
            cache_valid_d = 1'b0;
            replay_mode_d = 1'b0;
          end else if (replay && cache_valid_q) begin
            idx_d         = '0;
            state_d       = ST_RUN;
            replay_mode_d = 1'b1;
`endif
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
`ifdef SIMON_KEYSCHED_CACHE_EN
          cache_valid_d = 1'b0;
`endif
        end else if (rk_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
`ifdef SIMON_KEYSCHED_CACHE_EN
            cache_valid_d = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
`ifdef SIMON_KEYSCHED_CACHE_EN
            if (!replay_mode_q) begin
`endif
              for (int j = 0; j < M - 1; j++) begin
                win_d[j] = win_q[j+1];
              end
              win_d[M-1] = exp_key;
`ifdef SIMON_KEYSCHED_CACHE_EN
            end
`endif
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and window registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      for (int j = 0; j < M; j++) begin
        win_q[j] <= '0;
      end
`ifdef SIMON_KEYSCHED_CACHE_EN
      cache_valid_q <= 1'b0;
      replay_mode_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      win_q   <= win_d;
`ifdef SIMON_KEYSCHED_CACHE_EN
      cache_valid_q <= cache_valid_d;
      replay_mode_q <= replay_mode_d;
`endif
    end
  end

  assign rk_valid = (state_q == ST_RUN);
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign rk_index = idx_q;

`ifdef SIMON_KEYSCHED_CACHE_EN
  assign rk = !rk_valid      ? '0 :
              replay_mode_q  ? cache_mem[idx_q] : win_q[0];
`else
  assign rk = rk_valid ? win_q[0] : '0;
`endif

endmodule
